// File: rtl/io_map_pkg.sv
// ============================================================================
// Module   : io_map_pkg
// Brief    : I/O region address map, register indices and CTRL/STAT bit fields.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_map_pkg;

    // Byte offsets within the I/O region
    localparam logic [4:0] IO_LED    = 5'h00;
    localparam logic [4:0] IO_SW     = 5'h04;
    localparam logic [4:0] IO_BTN_EV = 5'h08;
    localparam logic [4:0] IO_CTRL   = 5'h0C;
    localparam logic [4:0] IO_PRESC  = 5'h10;
    localparam logic [4:0] IO_CNT    = 5'h14;
    localparam logic [4:0] IO_CMP    = 5'h18;
    localparam logic [4:0] IO_STAT   = 5'h1C;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int STAT_MATCH       = 0;

    // Top address nibble the data-memory mux decodes as the I/O region
    localparam logic [3:0] IO_BASE_NIBBLE = 4'hF;

    typedef enum logic [2:0] {
        REG_LED    = 3'd0,
        REG_SW     = 3'd1,
        REG_BTN_EV = 3'd2,
        REG_CTRL   = 3'd3,
        REG_PRESC  = 3'd4,
        REG_CNT    = 3'd5,
        REG_CMP    = 3'd6,
        REG_STAT   = 3'd7
    } io_reg_e;

    function automatic logic io_region_hit(input logic [3:0] addr_top_nibble);
        return addr_top_nibble == IO_BASE_NIBBLE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_io_regs_if.sv
// ============================================================================
// Module   : mmio_io_regs_if
// Brief    : Core-side store/load bus between the address mux and the I/O block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mmio_io_regs_if;
    logic [4:0]  addr;
    logic        io_wr;
    logic [31:0] wr_dat;
    logic [31:0] rd_io_dat;

    modport master (output addr, output io_wr, output wr_dat, input  rd_io_dat);
    modport slave  (input  addr, input  io_wr, input  wr_dat, output rd_io_dat);
endinterface

`default_nettype wire

// File: rtl/io_sync_edge.sv
// ============================================================================
// Module   : io_sync_edge
// Brief    : Two-flop input synchroniser with optional synced rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_sync_edge #(
    parameter int W    = 1,
    parameter bit EDGE = 1'b0
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic [W-1:0] i_d,
    output logic      [W-1:0] o_q,
    output logic      [W-1:0] o_rise
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

    generate
        if (EDGE) begin : g_edge
            logic [W-1:0] r_prev;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_prev <= '0;
                end else begin
                    r_prev <= r_sync;
                end
            end

            assign o_rise = r_sync & ~r_prev;
        end else begin : g_no_edge
            assign o_rise = '0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/mmio_io_regs.sv
// ============================================================================
// Module   : mmio_io_regs
// Brief    : LED/switch/button registers plus prescaled compare timer with IRQ.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_io_regs
    import io_map_pkg::*;
#(
    parameter int LED_W = 16,
    parameter int SW_W  = 16,
    parameter int BTN_W = 5
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    mmio_io_regs_if.slave         bus,
    input  wire logic [SW_W-1:0]  sw_in,
    input  wire logic [BTN_W-1:0] btn_in,
    output logic      [LED_W-1:0] led_out,
    output logic                  tmr_irq
);

    logic [LED_W-1:0] r_led;
    logic [BTN_W-1:0] r_btn_ev;
    logic [2:0]       r_ctrl;
    logic [15:0]      r_presc;
    logic [15:0]      r_pcnt;
    logic [31:0]      r_cnt;
    logic [31:0]      r_cmp;
    logic             r_match;

    logic [SW_W-1:0]  w_sw_sync;
    logic [SW_W-1:0]  w_unused_sw_rise;
    logic [BTN_W-1:0] w_btn_sync_unused;
    logic [BTN_W-1:0] w_btn_rise;

    io_reg_e          w_sel;
    logic             w_wr_led, w_wr_btn, w_wr_ctrl, w_wr_presc;
    logic             w_wr_cnt, w_wr_cmp, w_wr_stat;
    logic             w_tick;
    logic             w_match_set;
    logic [31:0]      w_rd;
    logic             w_unused;

    io_sync_edge #(.W(SW_W), .EDGE(1'b0)) u_sw_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    (sw_in),
        .o_q    (w_sw_sync),
        .o_rise (w_unused_sw_rise)
    );

    io_sync_edge #(.W(BTN_W), .EDGE(1'b1)) u_btn_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    (btn_in),
        .o_q    (w_btn_sync_unused),
        .o_rise (w_btn_rise)
    );

    // Byte lanes are not decoded; every access is a full word
    assign w_unused = &{1'b0, bus.addr[1:0]};
    assign w_sel    = io_reg_e'(bus.addr[4:2]);

    assign w_wr_led   = bus.io_wr && (w_sel == REG_LED);
    assign w_wr_btn   = bus.io_wr && (w_sel == REG_BTN_EV);
    assign w_wr_ctrl  = bus.io_wr && (w_sel == REG_CTRL);
    assign w_wr_presc = bus.io_wr && (w_sel == REG_PRESC);
    assign w_wr_cnt   = bus.io_wr && (w_sel == REG_CNT);
    assign w_wr_cmp   = bus.io_wr && (w_sel == REG_CMP);
    assign w_wr_stat  = bus.io_wr && (w_sel == REG_STAT);

    // A PRESC write restarts the prescale period, so it also swallows the tick
    assign w_tick      = r_ctrl[CTRL_EN] && (r_pcnt == r_presc) && !w_wr_presc;
    assign w_match_set = w_tick && !w_wr_cnt && (r_cnt == r_cmp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led   <= '0;
            r_ctrl  <= '0;
            r_presc <= '0;
            r_cmp   <= '0;
        end else begin
            if (w_wr_led)   r_led   <= bus.wr_dat[LED_W-1:0];
            if (w_wr_ctrl)  r_ctrl  <= bus.wr_dat[2:0];
            if (w_wr_presc) r_presc <= bus.wr_dat[15:0];
            if (w_wr_cmp)   r_cmp   <= bus.wr_dat;
        end
    end

    // Sticky flags: a set arriving with its write-1-to-clear survives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_ev <= '0;
            r_match  <= 1'b0;
        end else begin
            r_btn_ev <= (r_btn_ev & ~(w_wr_btn ? bus.wr_dat[BTN_W-1:0] : '0)) | w_btn_rise;
            r_match  <= (r_match & ~(w_wr_stat & bus.wr_dat[STAT_MATCH])) | w_match_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= '0;
        end else if (!r_ctrl[CTRL_EN] || w_wr_presc || (r_pcnt == r_presc)) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_wr_cnt) begin
            r_cnt <= bus.wr_dat;
        end else if (w_tick) begin
            if ((r_cnt == r_cmp) && r_ctrl[CTRL_AUTO_RELOAD]) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        w_rd = '0;
        case (w_sel)
            REG_LED:    w_rd[LED_W-1:0] = r_led;
            REG_SW:     w_rd[SW_W-1:0]  = w_sw_sync;
            REG_BTN_EV: w_rd[BTN_W-1:0] = r_btn_ev;
            REG_CTRL:   w_rd[2:0]       = r_ctrl;
            REG_PRESC:  w_rd[15:0]      = r_presc;
            REG_CNT:    w_rd            = r_cnt;
            REG_CMP:    w_rd            = r_cmp;
            REG_STAT:   w_rd[STAT_MATCH] = r_match;
            default:    w_rd            = '0;
        endcase
    end

    assign bus.rd_io_dat = w_rd;
    assign led_out       = r_led;
    assign tmr_irq       = r_match & r_ctrl[CTRL_IRQ_EN];

endmodule

`default_nettype wire

// File: tb/tb_mmio_io_regs.sv
// ============================================================================
// Module   : tb_mmio_io_regs
// Brief    : Scenario-driven scoreboard bench for the memory-mapped I/O block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_io_regs;
    import io_map_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sw_in;
    logic [4:0]  btn_in;
    logic [15:0] led_out;
    logic        tmr_irq;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    mmio_io_regs_if bus ();

    mmio_io_regs #(.LED_W(16), .SW_W(16), .BTN_W(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .sw_in   (sw_in),
        .btn_in  (btn_in),
        .led_out (led_out),
        .tmr_irq (tmr_irq)
    );

    always #5 clk = ~clk;

    // Called 1 time unit after an edge; returns 1 time unit after the write edge
    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        bus.addr   = a;
        bus.wr_dat = d;
        bus.io_wr  = 1'b1;
        @(posedge clk);
        #1;
        bus.io_wr  = 1'b0;
    endtask

    task automatic set_addr(input logic [4:0] a);
        bus.addr = a;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.io_wr = 1'b0; bus.addr = '0; bus.wr_dat = '0;
        sw_in = '0; btn_in = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        for (int i = 0; i < 8; i++) begin
            set_addr(5'(i * 4));
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.rd_io_dat !== exp_v) begin
                errors++;
                $display("FAIL reset_rd_%02h got %h exp %h", i * 4, bus.rd_io_dat, exp_v);
            end
        end
        exp_v = exp_q.pop_front();
        checks++;
        if ({16'h0, led_out} !== exp_v) begin
            errors++; $display("FAIL reset_led got %h exp %h", led_out, exp_v);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if ({31'h0, tmr_irq} !== exp_v) begin
            errors++; $display("FAIL reset_irq got %b exp %h", tmr_irq, exp_v);
        end
    endtask

    task automatic test_led();
        @(posedge clk); #1;
        exp_q.push_back(32'h0000_A5A5);
        exp_q.push_back(32'h0000_A5A5);
        bus_write(IO_LED, 32'h0000_A5A5);
        exp_v = exp_q.pop_front();
        checks++;
        if ({16'h0, led_out} !== exp_v) begin
            errors++; $display("FAIL led_out got %h exp %h", led_out, exp_v);
        end
        set_addr(IO_LED);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.rd_io_dat !== exp_v) begin
            errors++; $display("FAIL led_rd got %h exp %h", bus.rd_io_dat, exp_v);
        end
        exp_q.push_back(32'h0);
        bus_write(IO_SW, 32'hFFFF_FFFF);
        set_addr(IO_SW);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.rd_io_dat !== exp_v) begin
            errors++; $display("FAIL sw_ro got %h exp %h", bus.rd_io_dat, exp_v);
        end
    endtask

    task automatic test_sw();
        @(posedge clk); #1;
        sw_in = 16'h1234;
        bus.addr = IO_SW;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0000_1234);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.rd_io_dat !== exp_v) begin
                errors++; $display("FAIL sw_edge%0d got %h exp %h", k + 1, bus.rd_io_dat, exp_v);
            end
        end
    endtask

    task automatic test_btn();
        @(posedge clk); #1;
        btn_in = 5'b00100;
        bus.addr = IO_BTN_EV;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        repeat (2) @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.rd_io_dat !== exp_v) begin
            errors++; $display("FAIL btn_edge2 got %h exp %h", bus.rd_io_dat, exp_v);
        end
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.rd_io_dat !== exp_v) begin
            errors++; $display("FAIL btn_edge3 got %h exp %h", bus.rd_io_dat, exp_v);
        end
        // Clear while still held: must not re-set
        exp_q.push_back(32'h0);
        bus_write(IO_BTN_EV, 32'h4);
        repeat (3) @(posedge clk);
        #1;
        set_addr(IO_BTN_EV);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.rd_io_dat !== exp_v) begin
            errors++; $display("FAIL btn_held_w1c got %h exp %h", bus.rd_io_dat, exp_v);
        end
        repeat (3) @(posedge clk);
        #1 btn_in = '0;
        repeat (4) @(posedge clk);
        #1 btn_in = 5'b00100;
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_q.push_back(32'h4);
        bus_write(IO_BTN_EV, 32'h4);
        set_addr(IO_BTN_EV);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.rd_io_dat !== exp_v) begin
            errors++; $display("FAIL btn_set_vs_w1c got %h exp %h", bus.rd_io_dat, exp_v);
        end
        btn_in = '0;
    endtask

    task automatic test_timer();
        @(posedge clk); #1;
        bus_write(IO_PRESC, 32'd3);
        bus_write(IO_CMP, 32'd5);
        bus_write(IO_CTRL, 32'h7);
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        repeat (23) @(posedge clk);
        #1;
        set_addr(IO_CNT);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.rd_io_dat !== exp_v) begin
            errors++; $display("FAIL tmr_cnt_pre got %h exp %h", bus.rd_io_dat, exp_v);
        end
        set_addr(IO_STAT);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.rd_io_dat !== exp_v) begin
            errors++; $display("FAIL tmr_stat_pre got %h exp %h", bus.rd_io_dat, exp_v);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if ({31'h0, tmr_irq} !== exp_v) begin
            errors++; $display("FAIL tmr_irq_pre got %b exp %h", tmr_irq, exp_v);
        end
        @(posedge clk); #1;
        set_addr(IO_STAT);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.rd_io_dat !== exp_v) begin
            errors++; $display("FAIL tmr_stat_match got %h exp %h", bus.rd_io_dat, exp_v);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if ({31'h0, tmr_irq} !== exp_v) begin
            errors++; $display("FAIL tmr_irq_match got %b exp %h", tmr_irq, exp_v);
        end
        set_addr(IO_CNT);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.rd_io_dat !== exp_v) begin
            errors++; $display("FAIL tmr_cnt_reload got %h exp %h", bus.rd_io_dat, exp_v);
        end
        exp_q.push_back(32'd0);
        bus_write(IO_STAT, 32'h1);
        exp_v = exp_q.pop_front();
        checks++;
        if ({31'h0, tmr_irq} !== exp_v) begin
            errors++; $display("FAIL tmr_irq_w1c got %b exp %h", tmr_irq, exp_v);
        end
        bus_write(IO_CTRL, 32'h0);
    endtask

    task automatic test_wrap();
        logic [31:0] cnt_exp;
        bus_write(IO_PRESC, 32'd0);
        bus_write(IO_CMP, 32'h10);
        bus_write(IO_CNT, 32'hFFFF_FFFE);
        bus_write(IO_CTRL, 32'h1);
        for (int i = 0; i < 20; i++) begin
            cnt_exp = 32'hFFFF_FFFE + 32'(i);
            exp_q.push_back(cnt_exp);
            exp_q.push_back((i == 19) ? 32'd1 : 32'd0);
            set_addr(IO_CNT);
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.rd_io_dat !== exp_v) begin
                errors++; $display("FAIL wrap_cnt[%0d] got %h exp %h", i, bus.rd_io_dat, exp_v);
            end
            set_addr(IO_STAT);
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.rd_io_dat !== exp_v) begin
                errors++; $display("FAIL wrap_stat[%0d] got %h exp %h", i, bus.rd_io_dat, exp_v);
            end
            @(posedge clk); #1;
        end
        bus_write(IO_CTRL, 32'h0);
        bus_write(IO_STAT, 32'h1);
    endtask

    task automatic test_back_to_back();
        bus_write(IO_CMP, 32'h20);
        bus_write(IO_CNT, 32'h20);
        exp_q.push_back(32'h20);
        repeat (3) @(posedge clk);
        #1;
        set_addr(IO_CNT);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.rd_io_dat !== exp_v) begin
            errors++; $display("FAIL cnt_frozen got %h exp %h", bus.rd_io_dat, exp_v);
        end
        // Enable, then a CNT store lands on the first tick where CNT==CMP
        bus_write(IO_CTRL, 32'h1);
        bus_write(IO_CNT, 32'd7);
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd8);
        exp_q.push_back(32'd0);
        for (int k = 0; k < 2; k++) begin
            set_addr(IO_CNT);
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.rd_io_dat !== exp_v) begin
                errors++; $display("FAIL b2b_cnt[%0d] got %h exp %h", k, bus.rd_io_dat, exp_v);
            end
            set_addr(IO_STAT);
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.rd_io_dat !== exp_v) begin
                errors++; $display("FAIL b2b_stat[%0d] got %h exp %h", k, bus.rd_io_dat, exp_v);
            end
            if (k == 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_async_reset();
        bus_write(IO_CMP, 32'hC);
        bus_write(IO_CTRL, 32'h5);
        exp_q.push_back(32'd1);
        repeat (3) @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if ({31'h0, tmr_irq} !== exp_v) begin
            errors++; $display("FAIL prerst_irq got %b exp %h", tmr_irq, exp_v);
        end
        bus.addr = IO_CNT;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        #2 rst_n = 1'b0;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if ({16'h0, led_out} !== exp_v) begin
            errors++; $display("FAIL arst_led got %h exp %h", led_out, exp_v);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if ({31'h0, tmr_irq} !== exp_v) begin
            errors++; $display("FAIL arst_irq got %b exp %h", tmr_irq, exp_v);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.rd_io_dat !== exp_v) begin
            errors++; $display("FAIL arst_cnt got %h exp %h", bus.rd_io_dat, exp_v);
        end
        set_addr(IO_CTRL);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.rd_io_dat !== exp_v) begin
            errors++; $display("FAIL arst_ctrl got %h exp %h", bus.rd_io_dat, exp_v);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_led();
        test_sw();
        test_btn();
        test_timer();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
